estado_temp_multi: RTL and testbench
====================================

# estado_temp_multi

Parametrised successor to the temperature-state FSM. It classifies each valid temperature sample against configurable thresholds and counts persistence internally, so no external persistence counters are needed. Exit thresholds carry hysteresis, the cause of an alert is held in a register, and the alarm is latched until acknowledged. It sits between the sample register and the actuator drivers (heater and fan).

## Interface
- `W`, 11: signed temperature width.
- `TEMP_BAJO`, 180: cold entry threshold; a sample below it is cold.
- `TEMP_ALTO`, 259: hot entry threshold; a sample above it is hot.
- `HIST`, 5: hysteresis band width. Constraint: `TEMP_BAJO+HIST <= TEMP_ALTO-HIST`.
- `N_PER`, 4: consecutive out-of-range valid samples needed for ALERTA. Range 2..255.
- `CW`, `$clog2(N_PER+1)`: width of the persistence counter (derived).
- `clk` in 1: system clock, rising edge.
- `arst_n` in 1: reset, asynchronous, active-low.
- `muestra_valida` in 1: `temp` is a new sample this cycle.
- `temp` in W: signed temperature sample.
- `ack` in 1: clears the latched alarm.
- `alerta` out 1: high when the state is ALERTA.
- `calefactor` out 1: heater on (ALERTA with cold cause).
- `ventilador` out 1: fan on (ALERTA with hot cause).
- `alerta_mem` out 1: latched alarm, sticky until acknowledged.
- `estado_actual` out 2: NORMAL=00, BAJO=01, ALTO=10, ALERTA=11.
- `cuenta` out CW: persistence counter value.

## Operation
- Sample classification uses signed W-bit compares:
  - frio: `temp < TEMP_BAJO`.
  - calor: `temp > TEMP_ALTO`.
  - sale_frio: `temp >= TEMP_BAJO+HIST` and not calor.
  - sale_calor: `temp <= TEMP_ALTO-HIST` and not frio.
  - banda: neither frio/calor nor the exit condition that applies to the current state.
- State, `cuenta`, `causa` and `alerta_mem` update only on edges where `muestra_valida=1`. Otherwise everything holds, except the `ack` handling below.
- `causa` is an internal register: 0=cold, 1=hot.
- NORMAL:
  - frio → BAJO, cuenta=1, causa=0.
  - calor → ALTO, cuenta=1, causa=1.
  - else stay, cuenta=0.
- BAJO:
  - frio: cuenta+1; if it reaches N_PER → ALERTA.
  - calor → ALTO, cuenta=1, causa=1.
  - sale_frio → NORMAL, cuenta=0.
  - banda: stay, cuenta held.
- ALTO: mirror of BAJO, with cold and hot swapped and sale_calor as the exit condition.
- ALERTA:
  - Sample matching `causa`: stay, cuenta saturates at N_PER.
  - Exit condition for `causa` → NORMAL, cuenta=0.
  - Opposite out-of-range sample → opposite pre-alert state, cuenta=1, causa flipped.
  - banda: stay.
- Illegal state encoding → NORMAL on the next edge.
- Output decode is combinational from registered state and `causa` only, never from live `temp`:
  - `alerta` = (state==ALERTA).
  - `calefactor` = alerta & ~causa.
  - `ventilador` = alerta & causa.
- `alerta_mem`:
  - Set on the edge that enters ALERTA.
  - Cleared by `ack` on any edge, valid sample or not, when the state is not ALERTA and is not entering ALERTA.
  - If set and clear happen on the same edge, set wins. `ack` while in ALERTA is ignored.

## Timing
- All state is registered.
- Sample accepted at edge k → new state, `cuenta`, outputs and `alerta_mem` are visible after edge k. Latency is 1 cycle from sample to outputs.
- ALERTA is asserted after the edge that captures the N_PER-th consecutive out-of-range valid sample. Idle cycles (`muestra_valida=0`) do not break the run.
- `arst_n` low forces, immediately and independent of `clk`:
  - state=NORMAL, cuenta=0, causa=0, alerta_mem=0.
  - Therefore all outputs are 0.
- Reset mid-count discards the run. Counting restarts on the first valid sample after `arst_n` rises.

## Configuration
- `ESTADO_TEMP_HISTERESIS_EN` defined: hysteresis band as described above.
- Undefined: HIST is treated as 0, so sale_frio = (`temp >= TEMP_BAJO`) and sale_calor = (`temp <= TEMP_ALTO`). Exit equals entry and the banda case never occurs. All other behaviour is identical.

## Test plan
All scenarios use default parameters, with `ESTADO_TEMP_HISTERESIS_EN` defined unless stated.
- **Reset, then cold run.** Reset; 4 valid samples of 170 → after the 4th edge: estado_actual=11, alerta=1, calefactor=1, ventilador=0, cuenta=4, alerta_mem=1.
- **Interrupted cold run.** Samples 170,170,170,200 → estado_actual=00, cuenta=0, alerta and alerta_mem stay 0.
- **Hysteresis.** From cold ALERTA:
  - With the macro: 182 → stays 11; then 185 → 00, calefactor=0.
  - Without the macro: 182 → 00.
- **Hot run with gaps and a cold/hot switch.**
  - 4 samples of 300, each followed by 3 cycles with `muestra_valida=0` → ALERTA with ventilador=1 after the 4th valid edge.
  - Separately: 170,170,300 → estado_actual=10, cuenta=1.
- **Acknowledge.**
  - Leave ALERTA via 220 → alerta=0, alerta_mem=1.
  - `ack` pulse → alerta_mem=0.
  - `ack` held while in ALERTA → alerta_mem stays 1.
  - `ack` on the same edge as ALERTA entry → alerta_mem=1.
- **Asynchronous reset mid-run.** Drop `arst_n` mid-cycle at cuenta=3 → all outputs 0 before the next edge; after release, 4 new cold samples are needed for ALERTA.

Source files
------------

// File: rtl/estado_temp_multi.sv
// ---------------------------------------------------------------------------
// estado_temp_multi
//
// Temperature-state classifier with built-in persistence counting, hysteresis
// on the exit thresholds, a registered alert cause and a sticky alarm.
// Sits between the sample register and the heater/fan drivers.
//
// Optional feature macro: ESTADO_TEMP_HISTERESIS_EN
//   defined   -> exit thresholds are TEMP_BAJO+HIST / TEMP_ALTO-HIST
//   undefined -> HIST is ignored, exit thresholds equal entry thresholds
//
// Parameters
//   W          signed temperature width
//   TEMP_BAJO  cold entry threshold (temp <  TEMP_BAJO is cold)
//   TEMP_ALTO  hot entry threshold  (temp >  TEMP_ALTO is hot)
//   HIST       hysteresis band width
//   N_PER      consecutive out-of-range valid samples needed for ALERTA (2..255)
//   CW         persistence counter width (derived)
//
// Ports
//   clk            in   system clock, rising edge
//   arst_n         in   asynchronous active-low reset
//   muestra_valida in   temp carries a new sample this cycle
//   temp           in   signed temperature sample (two's complement, W bits)
//   ack            in   clears the latched alarm (outside ALERTA)
//   alerta         out  state is ALERTA
//   calefactor     out  heater on (ALERTA, cold cause)
//   ventilador     out  fan on (ALERTA, hot cause)
//   alerta_mem     out  latched alarm, sticky until acknowledged
//   estado_actual  out  NORMAL=00, BAJO=01, ALTO=10, ALERTA=11
//   cuenta         out  persistence counter
// ---------------------------------------------------------------------------
module estado_temp_multi #(
    parameter int W         = 11,
    parameter int TEMP_BAJO = 180,
    parameter int TEMP_ALTO = 259,
    parameter int HIST      = 5,
    parameter int N_PER     = 4,
    parameter int CW        = $clog2(N_PER + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          muestra_valida,
    input  logic [W-1:0]  temp,
    input  logic          ack,
    output logic          alerta,
    output logic          calefactor,
    output logic          ventilador,
    output logic          alerta_mem,
    output logic [1:0]    estado_actual,
    output logic [CW-1:0] cuenta
);

`ifdef ESTADO_TEMP_HISTERESIS_EN
    localparam int HIST_EF = HIST;
`else
    // Band collapsed: exit thresholds coincide with entry thresholds.
    localparam int HIST_EF = 0 * HIST;
`endif

    localparam logic signed [W-1:0] UMB_BAJO   = W'(TEMP_BAJO);
    localparam logic signed [W-1:0] UMB_ALTO   = W'(TEMP_ALTO);
    localparam logic signed [W-1:0] SAL_FRIO   = W'(TEMP_BAJO + HIST_EF);
    localparam logic signed [W-1:0] SAL_CALOR  = W'(TEMP_ALTO - HIST_EF);
    localparam logic [CW-1:0]       CUENTA_MAX = CW'(N_PER);
    localparam logic [CW-1:0]       CUENTA_UNO = CW'(1);
    localparam logic [CW-1:0]       CUENTA_CERO = '0;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cuenta_q, cuenta_d;
    logic          causa_q, causa_d;       // 0 = cold, 1 = hot
    logic          alerta_mem_q, alerta_mem_d;

    logic signed [W-1:0] temp_s;
    logic                frio, calor, sale_frio, sale_calor;
    logic [CW-1:0]       cuenta_inc;
    logic                entra_alerta;

    // Sample classification (signed compares)
    always_comb begin
        temp_s     = signed'(temp);
        frio       = (temp_s < UMB_BAJO);
        calor      = (temp_s > UMB_ALTO);
        sale_frio  = (temp_s >= SAL_FRIO) && !calor;
        sale_calor = (temp_s <= SAL_CALOR) && !frio;
        cuenta_inc = cuenta_q + CUENTA_UNO;
    end

    // Next-state logic; anything not matched below is the in-band case and holds.
    always_comb begin
        estado_d     = estado_q;
        cuenta_d     = cuenta_q;
        causa_d      = causa_q;
        alerta_mem_d = alerta_mem_q;
        entra_alerta = 1'b0;

        if (muestra_valida) begin
            unique case (estado_q)
                NORMAL: begin
                    if (frio) begin
                        estado_d = BAJO;
                        cuenta_d = CUENTA_UNO;
                        causa_d  = 1'b0;
                    end else if (calor) begin
                        estado_d = ALTO;
                        cuenta_d = CUENTA_UNO;
                        causa_d  = 1'b1;
                    end else begin
                        cuenta_d = CUENTA_CERO;
                    end
                end
                BAJO: begin
                    if (frio) begin
                        cuenta_d = cuenta_inc;
                        if (cuenta_inc == CUENTA_MAX) begin
                            estado_d = ALERTA;
                        end
                    end else if (calor) begin
                        estado_d = ALTO;
                        cuenta_d = CUENTA_UNO;
                        causa_d  = 1'b1;
                    end else if (sale_frio) begin
                        estado_d = NORMAL;
                        cuenta_d = CUENTA_CERO;
                    end
                end
                ALTO: begin
                    if (calor) begin
                        cuenta_d = cuenta_inc;
                        if (cuenta_inc == CUENTA_MAX) begin
                            estado_d = ALERTA;
                        end
                    end else if (frio) begin
                        estado_d = BAJO;
                        cuenta_d = CUENTA_UNO;
                        causa_d  = 1'b0;
                    end else if (sale_calor) begin
                        estado_d = NORMAL;
                        cuenta_d = CUENTA_CERO;
                    end
                end
                ALERTA: begin
                    if (!causa_q) begin
                        if (frio) begin
                            cuenta_d = CUENTA_MAX;
                        end else if (calor) begin
                            estado_d = ALTO;
                            cuenta_d = CUENTA_UNO;
                            causa_d  = 1'b1;
                        end else if (sale_frio) begin
                            estado_d = NORMAL;
                            cuenta_d = CUENTA_CERO;
                        end
                    end else begin
                        if (calor) begin
                            cuenta_d = CUENTA_MAX;
                        end else if (frio) begin
                            estado_d = BAJO;
                            cuenta_d = CUENTA_UNO;
                            causa_d  = 1'b0;
                        end else if (sale_calor) begin
                            estado_d = NORMAL;
                            cuenta_d = CUENTA_CERO;
                        end
                    end
                end
                default: begin
                    estado_d = NORMAL;
                    cuenta_d = CUENTA_CERO;
                end
            endcase
        end

        // Sticky alarm: entering ALERTA sets (and beats a simultaneous ack);
        // ack only clears while the state is outside ALERTA.
        entra_alerta = muestra_valida && (estado_d == ALERTA) && (estado_q != ALERTA);
        if (entra_alerta) begin
            alerta_mem_d = 1'b1;
        end else if (ack && (estado_q != ALERTA)) begin
            alerta_mem_d = 1'b0;
        end
    end

    // Registered state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q     <= NORMAL;
            cuenta_q     <= '0;
            causa_q      <= 1'b0;
            alerta_mem_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cuenta_q     <= cuenta_d;
            causa_q      <= causa_d;
            alerta_mem_q <= alerta_mem_d;
        end
    end

    // Output decode from registered state and cause only
    always_comb begin
        alerta        = (estado_q == ALERTA);
        calefactor    = alerta && !causa_q;
        ventilador    = alerta && causa_q;
        alerta_mem    = alerta_mem_q;
        estado_actual = estado_q;
        cuenta        = cuenta_q;
    end

endmodule

// File: tb/tb_estado_temp_multi.sv
// Scoreboard bench for estado_temp_multi with default parameters.
// Stimulus pushes the expected output vector for each issued cycle; monitors
// pop and compare after each clock edge (or on an asynchronous-reset probe).
module tb_estado_temp_multi;

    logic        clk;
    logic        arst_n;
    logic        muestra_valida;
    logic [10:0] temp;
    logic        ack;
    logic        alerta, calefactor, ventilador, alerta_mem;
    logic [1:0]  estado_actual;
    logic [2:0]  cuenta;

    estado_temp_multi dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .muestra_valida(muestra_valida),
        .temp          (temp),
        .ack           (ack),
        .alerta        (alerta),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .alerta_mem    (alerta_mem),
        .estado_actual (estado_actual),
        .cuenta        (cuenta)
    );

    typedef struct {
        string      nombre;
        logic [8:0] esp;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    event  ev_async;

    logic [8:0] act;
    assign act = {estado_actual, alerta, calefactor, ventilador, alerta_mem, cuenta};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic comparar(input item_t it);
        checks++;
        if (act !== it.esp) begin
            failures++;
            $display("FAIL %s: actual {est,al,cal,ven,mem,cnt}=%b_%b%b%b%b_%0d required=%b_%b%b%b%b_%0d",
                     it.nombre, act[8:7], act[6], act[5], act[4], act[3], act[2:0],
                     it.esp[8:7], it.esp[6], it.esp[5], it.esp[4], it.esp[3], it.esp[2:0]);
        end
    endtask

    // Monitor for clocked responses
    always begin
        @(posedge clk);
        #2;
        if (sb.size() > 0) comparar(sb.pop_front());
    end

    // Monitor for asynchronous-reset probes (no clock edge involved)
    always begin
        @(ev_async);
        if (sb.size() > 0) comparar(sb.pop_front());
    end

    function automatic logic [8:0] empaqueta(input logic [1:0] est, input bit cal,
                                             input bit ven, input bit mem, input int cnt);
        logic [2:0] c;
        c = cnt[2:0];
        return {est, (est == 2'b11), cal, ven, mem, c};
    endfunction

    task automatic paso(input bit v, input int t, input bit a, input string n,
                        input logic [1:0] est, input bit cal, input bit ven,
                        input bit mem, input int cnt);
        item_t it;
        @(negedge clk);
        muestra_valida = v;
        temp           = t[10:0];
        ack            = a;
        it.nombre      = n;
        it.esp         = empaqueta(est, cal, ven, mem, cnt);
        sb.push_back(it);
    endtask

    task automatic sonda_async(input string n);
        item_t it;
        it.nombre = n;
        it.esp    = '0;
        sb.push_back(it);
        -> ev_async;
        #1;
    endtask

    initial begin
        arst_n = 1'b0; muestra_valida = 1'b0; temp = '0; ack = 1'b0;
        #3;
        sonda_async("reset_inicial");
        @(negedge clk);
        arst_n = 1'b1;

        // Cold run to ALERTA
        paso(1, 170, 0, "frio1", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "frio2", 2'b01, 0, 0, 0, 2);
        paso(1, 170, 0, "frio3", 2'b01, 0, 0, 0, 3);
        paso(1, 170, 0, "frio4_alerta", 2'b11, 1, 0, 1, 4);

        // Hysteresis on leaving cold ALERTA
`ifdef ESTADO_TEMP_HISTERESIS_EN
        paso(1, 182, 0, "hist_banda", 2'b11, 1, 0, 1, 4);
`else
        paso(1, 182, 0, "hist_sin_banda", 2'b00, 0, 0, 1, 0);
`endif
        paso(1, 185, 0, "hist_sale", 2'b00, 0, 0, 1, 0);
        paso(0, 0, 1, "ack_pulso", 2'b00, 0, 0, 0, 0);

        // Interrupted cold run
        paso(1, 170, 0, "int1", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "int2", 2'b01, 0, 0, 0, 2);
        paso(1, 170, 0, "int3", 2'b01, 0, 0, 0, 3);
        paso(1, 200, 0, "int_sale", 2'b00, 0, 0, 0, 0);

        // Hot run with idle gaps
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) begin
                paso(1, 300, 0, "calor_run", 2'b10, 0, 0, 0, i);
                repeat (3) paso(0, 300, 0, "calor_hueco", 2'b10, 0, 0, 0, i);
            end else begin
                paso(1, 300, 0, "calor_alerta", 2'b11, 0, 1, 1, 4);
                repeat (3) paso(0, 300, 0, "alerta_hueco", 2'b11, 0, 1, 1, 4);
            end
        end

        // ack ignored in ALERTA; counter saturates
        paso(0, 0, 1, "ack_en_alerta", 2'b11, 0, 1, 1, 4);
        paso(1, 300, 1, "ack_alerta_sat", 2'b11, 0, 1, 1, 4);
        paso(1, 220, 0, "sale_220", 2'b00, 0, 0, 1, 0);
        paso(0, 0, 1, "ack_tras_220", 2'b00, 0, 0, 0, 0);

        // Cold/hot switch, then ack on the entry edge
        paso(1, 170, 0, "sw_f1", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "sw_f2", 2'b01, 0, 0, 0, 2);
        paso(1, 300, 0, "sw_calor", 2'b10, 0, 0, 0, 1);
        paso(1, 170, 0, "sw_frio", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "sw_f2b", 2'b01, 0, 0, 0, 2);
        paso(1, 170, 0, "sw_f3b", 2'b01, 0, 0, 0, 3);
        paso(1, 170, 1, "ack_misma_entrada", 2'b11, 1, 0, 1, 4);

        // Opposite sample from cold ALERTA, then hot ALERTA, then back to cold
        paso(1, 300, 0, "alerta_opuesta", 2'b10, 0, 0, 1, 1);
        paso(1, 300, 0, "op2", 2'b10, 0, 0, 1, 2);
        paso(1, 300, 0, "op3", 2'b10, 0, 0, 1, 3);
        paso(1, 300, 0, "op4_alerta", 2'b11, 0, 1, 1, 4);
        paso(1, 170, 0, "alerta_calor_a_frio", 2'b01, 0, 0, 1, 1);
        paso(1, 185, 0, "bajo_sale", 2'b00, 0, 0, 1, 0);
        paso(0, 0, 1, "ack3", 2'b00, 0, 0, 0, 0);

        // Band inside BAJO
        paso(1, 170, 0, "banda_f1", 2'b01, 0, 0, 0, 1);
`ifdef ESTADO_TEMP_HISTERESIS_EN
        paso(1, 182, 0, "banda_bajo", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "banda_sigue", 2'b01, 0, 0, 0, 2);
`else
        paso(1, 182, 0, "sin_banda_bajo", 2'b00, 0, 0, 0, 0);
        paso(1, 170, 0, "sin_banda_f", 2'b01, 0, 0, 0, 1);
`endif
        paso(1, 185, 0, "banda_sale", 2'b00, 0, 0, 0, 0);

        // Threshold boundaries and negative samples
        paso(1, 180, 0, "lim_180", 2'b00, 0, 0, 0, 0);
        paso(1, 259, 0, "lim_259", 2'b00, 0, 0, 0, 0);
        paso(1, 179, 0, "lim_179", 2'b01, 0, 0, 0, 1);
        paso(1, 259, 0, "bajo_259", 2'b00, 0, 0, 0, 0);
        paso(1, 260, 0, "lim_260", 2'b10, 0, 0, 0, 1);
`ifdef ESTADO_TEMP_HISTERESIS_EN
        paso(1, 255, 0, "banda_alto", 2'b10, 0, 0, 0, 1);
`else
        paso(1, 255, 0, "sin_banda_alto", 2'b00, 0, 0, 0, 0);
`endif
        paso(1, 254, 0, "alto_254", 2'b00, 0, 0, 0, 0);
        paso(1, -100, 0, "negativo", 2'b01, 0, 0, 0, 1);
        paso(1, 185, 0, "neg_sale", 2'b00, 0, 0, 0, 0);

        // Asynchronous reset at cuenta=3
        paso(1, 170, 0, "rst_f1", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "rst_f2", 2'b01, 0, 0, 0, 2);
        paso(1, 170, 0, "rst_f3", 2'b01, 0, 0, 0, 3);
        @(posedge clk);
        #3;
        muestra_valida = 1'b0;
        arst_n = 1'b0;
        #1;
        sonda_async("reset_async");
        @(negedge clk);
        arst_n = 1'b1;
        paso(1, 170, 0, "post_f1", 2'b01, 0, 0, 0, 1);
        paso(1, 170, 0, "post_f2", 2'b01, 0, 0, 0, 2);
        paso(1, 170, 0, "post_f3", 2'b01, 0, 0, 0, 3);
        paso(1, 170, 0, "post_f4_alerta", 2'b11, 1, 0, 1, 4);

        @(negedge clk);
        muestra_valida = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
